rgb_pixel_streamer: RTL and testbench

Front-end source for the grayscale pipeline. On command from the controller, it reads the colour image from the first read/write memory as a byte stream in R, G, B order. It drives that stream, with a valid strobe, into the grayscaler's input bus and honours the grayscaler's `pause` back-pressure. It is the producer end of the `Din` / `RWM_valid` / `pause` interface and signals frame completion to the controller.

---
 rtl/rgb_pixel_streamer_pkg.sv | 20 ++
 rtl/stream_addr_gen.sv | 42 ++++
 rtl/rgb_pixel_streamer.sv | 100 ++++++++++
 tb/tb_rgb_pixel_streamer.sv | 335 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rgb_pixel_streamer_pkg.sv
// Shared definitions for the grayscale pipeline front end: streamer states,
// bytes per pixel and the frame byte count used by streamer, grayscaler and controller.
package rgb_pixel_streamer_pkg;

  typedef enum logic [2:0] {
    IDLE,
    STREAM,
    DRAIN,
    DONE,
    REARM
  } stream_state_e;

  localparam int unsigned RGB_BYTES = 3;

  // Bytes in one N x M colour frame stored as interleaved R, G, B.
  function automatic int unsigned frame_bytes(input int unsigned n, input int unsigned m);
    return RGB_BYTES * n * m;
  endfunction

endpackage

// File: rtl/stream_addr_gen.sv
// Byte index counter for the RGB streamer: clear/increment control, memory
// address generation and detection of the final byte of the frame.
module stream_addr_gen
  import rgb_pixel_streamer_pkg::*;
#(
  parameter int          ADDR_W    = 8,
  parameter int          BASE_ADDR = 0,
  parameter int unsigned TOTAL     = 12
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clear_i,
  input  logic              incr_i,
  output logic [ADDR_W-1:0] addr_o,
  output logic              terminal_o
);

  logic [ADDR_W-1:0] idx_q, idx_d;

  // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    idx_d = idx_q;
    if (clear_i) begin
      idx_d = '0;
    end else if (incr_i) begin
      idx_d = idx_q + ADDR_W'(1);
    end
  end

  // NOTE: state registers use non-blocking assignments so all flops update together at the edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx_q <= '0;
    end else begin
      idx_q <= idx_d;
    end
  end

  assign addr_o     = ADDR_W'(BASE_ADDR) + idx_q;
  assign terminal_o = (idx_q == ADDR_W'(TOTAL - 1));

endmodule

// File: rtl/rgb_pixel_streamer.sv
// Producer end of the Din/RWM_valid/pause interface: streams the colour frame
// from memory as R, G, B bytes and pulses src_done when the frame is complete.
module rgb_pixel_streamer
  import rgb_pixel_streamer_pkg::*;
#(
  parameter int N         = 2,
  parameter int M         = 2,
  parameter int ADDR_W    = 8,
  parameter int BASE_ADDR = 0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              src_enable,
  input  logic              pause,
  output logic              mem_rd_en,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [7:0]        mem_rdata,
  output logic [7:0]        Dout,
  output logic              RWM_valid,
  output logic              last_byte,
  output logic              src_done
);

  localparam int unsigned TOTAL = frame_bytes(N, M);

  stream_state_e state_q, state_d;
  logic          rd_en;
  logic          clear;
  logic          terminal;
  logic          done;
  logic          valid_q;
  logic          last_q;

  stream_addr_gen #(
    .ADDR_W    (ADDR_W),
    .BASE_ADDR (BASE_ADDR),
    .TOTAL     (TOTAL)
  ) u_addr_gen (
    .clk        (clk),
    .rst_n      (rst_n),
    .clear_i    (clear),
    .incr_i     (rd_en),
    .addr_o     (mem_addr),
    .terminal_o (terminal)
  );

  always_comb begin
    state_d = state_q;
    rd_en   = 1'b0;
    clear   = 1'b0;
    done    = 1'b0;
    unique case (state_q)
      IDLE: begin
        clear = 1'b1;
        if (src_enable) state_d = STREAM;
      end
      STREAM: begin
        // A read issued in the abort cycle is still presented next cycle.
        rd_en = !pause;
        if (!src_enable) begin
          state_d = IDLE;
          clear   = 1'b1;
        end else if (rd_en && terminal) begin
          state_d = DRAIN;
        end
      end
      DRAIN: begin
        state_d = src_enable ? DONE : IDLE;
      end
      DONE: begin
        done    = 1'b1;
        state_d = REARM;
      end
      REARM: begin
        // Hold here until the controller drops enable, so a held enable cannot restart the frame.
        if (!src_enable) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      valid_q <= 1'b0;
      last_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      valid_q <= rd_en;
      last_q  <= rd_en && terminal;
    end
  end

  assign mem_rd_en = rd_en;
  assign RWM_valid = valid_q;
  assign Dout      = valid_q ? mem_rdata : 8'h00;
  assign last_byte = valid_q && last_q;
  assign src_done  = done;

endmodule

// File: tb/tb_rgb_pixel_streamer.sv
// Self-checking bench for rgb_pixel_streamer: a memory model feeds the DUT and a
// scoreboard of expected bytes is compared against the presented stream.
module tb_rgb_pixel_streamer;

  localparam int N         = 2;
  localparam int M         = 2;
  localparam int ADDR_W    = 8;
  localparam int BASE_ADDR = 0;
  localparam int TOTAL     = 3 * N * M;

  typedef struct packed {
    logic [7:0] data;
    logic       last;
  } exp_t;

  logic              clk;
  logic              rst_n;
  logic              src_enable;
  logic              pause;
  logic              mem_rd_en;
  logic [ADDR_W-1:0] mem_addr;
  logic [7:0]        mem_rdata;
  logic [7:0]        Dout;
  logic              RWM_valid;
  logic              last_byte;
  logic              src_done;

  logic [7:0] mem [0:255];
  exp_t       sb [$];
  int         checks;
  int         failures;

  rgb_pixel_streamer #(
    .N         (N),
    .M         (M),
    .ADDR_W    (ADDR_W),
    .BASE_ADDR (BASE_ADDR)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .src_enable (src_enable),
    .pause      (pause),
    .mem_rd_en  (mem_rd_en),
    .mem_addr   (mem_addr),
    .mem_rdata  (mem_rdata),
    .Dout       (Dout),
    .RWM_valid  (RWM_valid),
    .last_byte  (last_byte),
    .src_done   (src_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 8'(8'h10 + i);
    mem_rdata = 8'h00;
  end

  always @(posedge clk) begin
    if (mem_rd_en) mem_rdata <= mem[mem_addr];
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic push_frame();
    exp_t e;
    for (int k = 0; k < TOTAL; k++) begin
      e.data = 8'(8'h10 + BASE_ADDR + k);
      e.last = (k == TOTAL - 1);
      sb.push_back(e);
    end
  endtask

  task automatic idle_gap();
    src_enable = 1'b0;
    pause      = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  // Runs one frame from the current negedge. mode 0: no pause; 1: pause on every
  // presented B byte; 2: hold pause for 5 cycles starting when byte hold_at is presented.
  task automatic stream_frame(input int mode, input int hold_at, output int done_cyc, output int gaps);
    exp_t e;
    int   presented;
    int   hold_left;
    logic prev_valid;
    push_frame();
    presented  = 0;
    hold_left  = 0;
    prev_valid = 1'b0;
    done_cyc   = -1;
    gaps       = 0;
    pause      = 1'b0;
    src_enable = 1'b1;
    for (int cyc = 1; cyc <= 60; cyc++) begin
      @(negedge clk);
      if (cyc == 1) begin
        checks++;
        if (mem_rd_en !== 1'b1 || mem_addr !== 8'(BASE_ADDR)) begin
          failures++;
          $display("FAIL first_read: rd_en=%b addr=%h, expected rd_en=1 addr=%h", mem_rd_en, mem_addr, 8'(BASE_ADDR));
        end
      end
      if (RWM_valid === 1'b1) begin
        checks++;
        if (sb.size() == 0) begin
          failures++;
          $display("FAIL extra_byte: got %h, expected no byte", Dout);
        end else begin
          e = sb.pop_front();
          if (Dout !== e.data || last_byte !== e.last) begin
            failures++;
            $display("FAIL stream_byte: got %h last=%b, expected %h last=%b", Dout, last_byte, e.data, e.last);
          end
        end
        presented++;
      end else if (presented > 0 && presented < TOTAL) begin
        gaps++;
        if (mode == 1) begin
          checks++;
          if (!prev_valid || ((presented - 1) % 3) != 2) begin
            failures++;
            $display("FAIL pause_gap: idle after byte index %0d (prev_valid=%b), expected only one idle after a B byte", presented - 1, prev_valid);
          end
        end
      end
      prev_valid = RWM_valid;
      if (src_done === 1'b1) begin
        done_cyc = cyc;
        break;
      end
      if (mode == 1) begin
        pause = RWM_valid && (((presented - 1) % 3) == 2);
      end else if (mode == 2) begin
        if (RWM_valid === 1'b1 && presented - 1 == hold_at) hold_left = 5;
        pause = (hold_left > 0);
        if (hold_left > 0) begin
          #1;
          checks++;
          if (mem_rd_en !== 1'b0) begin
            failures++;
            $display("FAIL pause_hold_rd: rd_en=%b, expected 0", mem_rd_en);
          end
          if (hold_left < 5) begin
            checks++;
            if (RWM_valid !== 1'b0) begin
              failures++;
              $display("FAIL pause_hold_valid: RWM_valid=%b, expected 0", RWM_valid);
            end
          end
          hold_left--;
        end
      end
    end
    pause = 1'b0;
    checks++;
    if (sb.size() != 0) begin
      failures++;
      $display("FAIL frame_incomplete: %0d bytes missing, expected 0", sb.size());
    end
    @(negedge clk);
    checks++;
    if (src_done !== 1'b0 || RWM_valid !== 1'b0) begin
      failures++;
      $display("FAIL done_pulse: src_done=%b valid=%b one cycle later, expected 0 0", src_done, RWM_valid);
    end
    sb.delete();
  endtask

  task automatic check_reset_outputs(input string tag);
    checks++;
    if (mem_rd_en !== 1'b0 || mem_addr !== 8'(BASE_ADDR) || Dout !== 8'h00 ||
        RWM_valid !== 1'b0 || last_byte !== 1'b0 || src_done !== 1'b0) begin
      failures++;
      $display("FAIL %s: rd_en=%b addr=%h Dout=%h valid=%b last=%b done=%b, expected 0 %h 00 0 0 0",
               tag, mem_rd_en, mem_addr, Dout, RWM_valid, last_byte, src_done, 8'(BASE_ADDR));
    end
  endtask

  task automatic test_reset();
    rst_n      = 1'b0;
    src_enable = 1'b0;
    pause      = 1'b0;
    repeat (3) @(negedge clk);
    check_reset_outputs("reset_values");
    rst_n = 1'b1;
    @(negedge clk);
    check_reset_outputs("idle_after_reset");
  endtask

  task automatic test_basic_frame();
    int done_cyc, gaps;
    stream_frame(0, 0, done_cyc, gaps);
    checks++;
    if (done_cyc != TOTAL + 2 || gaps != 0) begin
      failures++;
      $display("FAIL basic_timing: done at cycle %0d gaps %0d, expected %0d and 0", done_cyc, gaps, TOTAL + 2);
    end
  endtask

  task automatic test_rearm();
    int activity, done_cyc, gaps;
    activity = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (mem_rd_en === 1'b1 || RWM_valid === 1'b1 || src_done === 1'b1) activity++;
    end
    checks++;
    if (activity != 0) begin
      failures++;
      $display("FAIL rearm_hold: %0d active cycles with enable held, expected 0", activity);
    end
    idle_gap();
    stream_frame(0, 0, done_cyc, gaps);
    checks++;
    if (done_cyc != TOTAL + 2 || gaps != 0) begin
      failures++;
      $display("FAIL second_frame: done at cycle %0d gaps %0d, expected %0d and 0", done_cyc, gaps, TOTAL + 2);
    end
  endtask

  task automatic test_pause_b_bytes();
    int done_cyc, gaps;
    idle_gap();
    stream_frame(1, 0, done_cyc, gaps);
    checks++;
    if (done_cyc != TOTAL + 5 || gaps != 3) begin
      failures++;
      $display("FAIL pause_b_timing: done at cycle %0d gaps %0d, expected %0d and 3", done_cyc, gaps, TOTAL + 5);
    end
  endtask

  task automatic test_pause_hold(input int hold_at);
    int done_cyc, gaps;
    idle_gap();
    stream_frame(2, hold_at, done_cyc, gaps);
    checks++;
    if (done_cyc != TOTAL + 7 || gaps != 5) begin
      failures++;
      $display("FAIL pause_hold_timing at %0d: done at cycle %0d gaps %0d, expected %0d and 5", hold_at, done_cyc, gaps, TOTAL + 7);
    end
  endtask

  task automatic test_abort();
    exp_t e;
    int   presented, extra, saw_done, done_cyc, gaps;
    logic dropped;
    idle_gap();
    push_frame();
    presented  = 0;
    extra      = 0;
    saw_done   = 0;
    dropped    = 1'b0;
    src_enable = 1'b1;
    for (int cyc = 0; cyc < 16; cyc++) begin
      @(negedge clk);
      if (src_done === 1'b1) saw_done++;
      if (RWM_valid === 1'b1) begin
        checks++;
        e = sb.pop_front();
        if (Dout !== e.data) begin
          failures++;
          $display("FAIL abort_byte: got %h, expected %h", Dout, e.data);
        end
        presented++;
        if (dropped) extra++;
      end
      if (!dropped && presented == 5) begin
        src_enable = 1'b0;
        dropped    = 1'b1;
      end
    end
    checks++;
    if (!dropped || extra > 1 || saw_done != 0) begin
      failures++;
      $display("FAIL abort: dropped=%b extra=%0d done_pulses=%0d, expected 1 <=1 0", dropped, extra, saw_done);
    end
    check_reset_outputs("abort_idle");
    sb.delete();
    stream_frame(0, 0, done_cyc, gaps);
    checks++;
    if (done_cyc != TOTAL + 2 || gaps != 0) begin
      failures++;
      $display("FAIL abort_restart: done at cycle %0d gaps %0d, expected %0d and 0", done_cyc, gaps, TOTAL + 2);
    end
  endtask

  task automatic test_reset_mid_frame();
    int presented, done_cyc, gaps;
    idle_gap();
    presented  = 0;
    src_enable = 1'b1;
    for (int cyc = 0; cyc < 30 && presented < 8; cyc++) begin
      @(negedge clk);
      if (RWM_valid === 1'b1) presented++;
    end
    checks++;
    if (presented != 8) begin
      failures++;
      $display("FAIL reset_mid_reach: presented %0d bytes, expected 8", presented);
    end
    rst_n = 1'b0;
    #1;
    check_reset_outputs("reset_mid_frame");
    @(negedge clk);
    rst_n = 1'b1;
    stream_frame(0, 0, done_cyc, gaps);
    checks++;
    if (done_cyc != TOTAL + 2 || gaps != 0) begin
      failures++;
      $display("FAIL reset_restart: done at cycle %0d gaps %0d, expected %0d and 0", done_cyc, gaps, TOTAL + 2);
    end
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    test_reset();
    test_basic_frame();
    test_rearm();
    test_pause_b_bytes();
    test_pause_hold(3);
    test_pause_hold(TOTAL - 2);
    test_abort();
    test_reset_mid_frame();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
